// File: rtl/unadder_pkg.sv
// Shared definitions for the bit-serial un-adder: FSM encoding and default widths.
package unadder_pkg;

    localparam int AW_DEF = 8;   // recovered addend / known addend width
    localparam int RW_DEF = 16;  // sum width, must be >= AW+1
    localparam int CW_DEF = 4;   // bit counter width, 2^CW >= RW

    // 2'b11 is unreachable and is treated as IDLE by the top-level FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/fs_bit.sv
// One-bit full subtractor: d = r - b - bin, bout = borrow into the next bit.
module fs_bit (
    input  logic r,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow-out of a single bit position.
    always_comb begin
        d    = r ^ b ^ bin;
        bout = (~r & b) | (~r & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_sub_unadder.sv
// Bit-serial inverse adder: recovers A = res - B one bit per clock, LSB first,
// and flags whether the result is a legal AW-bit addend.
module serial_sub_unadder
    import unadder_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int RW = RW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] res,
    input  logic [AW-1:0] B,
    output logic [AW-1:0] A,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] r_sh;      // remaining bits of res, LSB consumed first
    logic [RW-1:0] b_sh;      // remaining bits of zero-extended B
    logic [RW-1:0] d_sh;      // difference bits, shifted in at the MSB
    logic          br;        // running borrow between bit positions
    logic [CW-1:0] cnt;
    logic          d_bit;
    logic          br_nxt;
    logic [RW-1:0] d_nxt;
    logic          load;
    logic          shift_en;
    logic          last;

    fs_bit u_fs_bit (
        .r    (r_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    assign d_nxt = {d_bit, d_sh[RW-1:1]};
    assign last  = (cnt == CW'(RW - 1));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake decode; the unused encoding behaves like IDLE.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = IDLE;
        load      = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            SHIFT: begin
                busy      = 1'b1;
                shift_en  = 1'b1;
                state_nxt = last ? DONE : SHIFT;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
        endcase
    end

    // Serial datapath: capture on accept, one subtract step per SHIFT cycle,
    // and register A/valid from the final step's results on the last edge.
    // NOTE: all datapath registers, shift registers included, are reset so an abort leaves no stale state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            A     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            r_sh <= res;
            b_sh <= {{(RW-AW){1'b0}}, B};
            d_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (shift_en) begin
            r_sh <= r_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= d_nxt;
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
                A     <= d_nxt[AW-1:0];
                valid <= ~br_nxt & (d_nxt[RW-1:AW] == '0);
            end
        end
    end

endmodule
